// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider_lzc.sv
// Leading-zero counter: number of zero bits above the most significant one (W when in is zero).
module leading_zero_count #(
    parameter int W = 4
) (
    input  logic [W-1:0]             in,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int CW = $clog2(W + 1);

    // Ascending scan so the highest set bit overwrites any lower one.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (in[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle after a
// single-cycle skip over the dividend's leading zeros.
//
//   state | meaning
//   IDLE  | waiting for start
//   SKIP  | normalise dividend, load iteration count
//   ITER  | one restoring step per cycle
//   DONE  | result presented, done pulse; accepts a new start
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);

    div_state_t    state;
    logic [W-1:0]  d_reg;
    logic [W-1:0]  v_reg;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  r_reg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lz;

    logic [W:0]    t;
    logic          ge;
    logic [W-1:0]  r_sub;
    logic [W-1:0]  r_next;
    logic [W-1:0]  q_next;

    leading_zero_count #(.W(W)) u_lzc (
        .in    (d_reg),
        .count (lz)
    );

    // R < V always, so the difference fits in W bits and the carry-out can be dropped.
    assign t      = {r_reg, d_reg[W-1]};
    assign ge     = (t >= {1'b0, v_reg});
    assign r_sub  = t[W-1:0] - v_reg;
    assign r_next = ge ? r_sub : t[W-1:0];
    assign q_next = {q_reg[W-2:0], ge};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            d_reg       <= '0;
            v_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        d_reg       <= dividend;
                        v_reg       <= divisor;
                        q_reg       <= '0;
                        r_reg       <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            state <= SKIP;
                            busy  <= 1'b1;
                        end
                    end
                end
                SKIP: begin
                    d_reg <= d_reg << lz;
                    cnt   <= CW'(W) - lz;
                    if (d_reg == '0) begin
                        state     <= DONE;
                        quotient  <= q_reg;
                        remainder <= r_reg;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state <= ITER;
                        busy  <= 1'b1;
                    end
                end
                ITER: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    d_reg <= d_reg << 1;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        quotient  <= q_next;
                        remainder <= r_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (W=4) with a scoreboard of expected results and latencies.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rstN;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    typedef struct {
        int q;
        int r;
        int dbz;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   nb;
        nb = 0;
        for (int i = 0; i < W; i++) if (((a >> i) & 1) == 1) nb = i + 1;
        if (b == 0) begin
            e.q = (1 << W) - 1; e.r = a; e.dbz = 1; e.lat = 1;
        end else if (a == 0) begin
            e.q = 0; e.r = 0; e.dbz = 0; e.lat = 2;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 0; e.lat = 2 + nb;
        end
        return e;
    endfunction

    // Drives a start for one edge (the sampling edge) and records the expected result.
    task automatic start_op(input int a, input int b);
        sb.push_back(model(a, b));
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after the sampling edge; optionally pulses a stray start at edge count inj.
    task automatic wait_and_check(input int inj, input int ia, input int ib);
        int   lat;
        int   bc;
        exp_t e;
        lat = 1;
        bc  = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            if (lat == inj) begin
                dividend = W'(ia);
                divisor  = W'(ib);
                start    = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (done) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("quotient", {28'd0, quotient}, e.q);
                chk("remainder", {28'd0, remainder}, e.r);
                chk("div_by_zero", {31'd0, div_by_zero}, e.dbz);
                chk("latency", lat, e.lat);
                chk("busy_cycles", bc, e.lat - 1);
            end
        end
    endtask

    task automatic run_op(input int a, input int b);
        @(negedge clk);
        start_op(a, b);
        wait_and_check(0, 0, 0);
        @(posedge clk);
        #1 chk("done_pulse_end", {31'd0, done}, 32'd0);
    endtask

    int ta[8] = '{8, 6, 15, 5, 2, 15, 9, 0};
    int tb[8] = '{3, 7, 1, 5, 15, 15, 0, 0};

    initial begin
        rstN     = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_quotient", {28'd0, quotient}, 32'd0);
        chk("rst_remainder", {28'd0, remainder}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        run_op(13, 3);
        run_op(1, 1);
        run_op(0, 5);
        run_op(7, 0);

        // Stray start during ITER is ignored; start in the DONE cycle is taken back-to-back.
        @(negedge clk);
        start_op(15, 4);
        wait_and_check(3, 9, 2);
        start_op(9, 2);
        chk("hold_quotient", {28'd0, quotient}, 32'd3);
        chk("hold_remainder", {28'd0, remainder}, 32'd3);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_and_check(0, 0, 0);

        for (int i = 0; i < 8; i++) run_op(ta[i], tb[i]);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        start_op(12, 5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("arst_quotient", {28'd0, quotient}, 32'd0);
        chk("arst_remainder", {28'd0, remainder}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("arst_no_done", {31'd0, done}, 32'd0);
        end
        sb.delete();
        @(negedge clk);
        rstN = 1'b1;
        run_op(12, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
